// File: rtl/upb_packet_fifo_pkg.sv
// Shared types for the packet FIFO: the registered status flag bundle and its reset value.
package upb_packet_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic rderr;
    logic wrerr;
    logic below_low;
    logic above_high;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RESET_C = '{
    full:       1'b0,
    empty:      1'b1,
    rderr:      1'b0,
    wrerr:      1'b0,
    below_low:  1'b1,
    above_high: 1'b0
  };

endpackage

// File: rtl/upb_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous (combinational) read.
module upb_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [DEPTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [0:(2**DEPTH)-1];

  // Storage write port
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/upb_packet_fifo.sv
// Packet FIFO: data words become visible to the reader only once their packet is committed;
// a partially written packet can be reverted. Fill-level thresholds drive flow control.
module upb_packet_fifo
  import upb_packet_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int METADATA_WIDTH = 8,
  parameter int DATA_DEPTH     = 3,
  parameter int METADATA_DEPTH = 2,
  parameter int LOW_THRESHOLD  = 3,
  parameter int HIGH_THRESHOLD = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     DI,
  input  logic [METADATA_WIDTH-1:0] MI,
  input  logic                      WREN,
  input  logic                      COMMIT,
  input  logic                      REVERT,
  input  logic                      RDEN,
  output logic [DATA_WIDTH-1:0]     DO,
  output logic [METADATA_WIDTH-1:0] MO,
  output logic                      EOP,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic                      RDERR,
  output logic                      WRERR,
  output logic                      BELOW_LOW,
  output logic                      ABOVE_HIGH
);

  localparam logic [DATA_DEPTH:0]     DPTR_ONE_C     = {{DATA_DEPTH{1'b0}}, 1'b1};
  localparam logic [METADATA_DEPTH:0] MPTR_ONE_C     = {{METADATA_DEPTH{1'b0}}, 1'b1};
  localparam logic [DATA_DEPTH:0]     DATA_ENTRIES_C = {1'b1, {DATA_DEPTH{1'b0}}};
  localparam logic [METADATA_DEPTH:0] META_ENTRIES_C = {1'b1, {METADATA_DEPTH{1'b0}}};
  localparam logic [METADATA_DEPTH:0] META_NONE_C    = {(METADATA_DEPTH+1){1'b0}};
  localparam logic [DATA_DEPTH:0]     LOW_TH_C       = LOW_THRESHOLD[DATA_DEPTH:0];
  localparam logic [DATA_DEPTH:0]     HIGH_TH_C      = HIGH_THRESHOLD[DATA_DEPTH:0];

  logic [DATA_DEPTH:0]     rd_ptr_r, wr_ptr_r, cm_ptr_r;
  logic [DATA_DEPTH:0]     rd_ptr_nxt_s, wr_ptr_nxt_s, cm_ptr_nxt_s, occ_nxt_s;
  logic [METADATA_DEPTH:0] mrd_ptr_r, mwr_ptr_r;
  logic [METADATA_DEPTH:0] mrd_ptr_nxt_s, mwr_ptr_nxt_s, mcnt_nxt_s;
  fifo_status_t            status_r, status_nxt_s;
  logic                    wr_ok_s, rd_ok_s, data_we_s, meta_we_s;
  logic [DATA_WIDTH:0]     data_rd_s;
  logic [METADATA_WIDTH-1:0] meta_rd_s;

  upb_fifo_mem #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(DATA_DEPTH)
  ) u_data_mem (
    .CLK  (CLK),
    .we   (data_we_s),
    .waddr(wr_ptr_r[DATA_DEPTH-1:0]),
    .wdata({COMMIT, DI}),
    .raddr(rd_ptr_r[DATA_DEPTH-1:0]),
    .rdata(data_rd_s)
  );

  upb_fifo_mem #(
    .WIDTH(METADATA_WIDTH),
    .DEPTH(METADATA_DEPTH)
  ) u_meta_mem (
    .CLK  (CLK),
    .we   (meta_we_s),
    .waddr(mwr_ptr_r[METADATA_DEPTH-1:0]),
    .wdata(MI),
    .raddr(mrd_ptr_r[METADATA_DEPTH-1:0]),
    .rdata(meta_rd_s)
  );

  // Next-state pointers and flags; FULL/EMPTY gating uses pre-edge registered status
  always_comb begin
    wr_ok_s       = WREN & ~status_r.full;
    rd_ok_s       = RDEN & ~status_r.empty;
    // REVERT discards a same-cycle word, so it never reaches memory
    data_we_s     = wr_ok_s & ~REVERT;
    meta_we_s     = data_we_s & COMMIT;
    rd_ptr_nxt_s  = rd_ptr_r;
    mrd_ptr_nxt_s = mrd_ptr_r;
    wr_ptr_nxt_s  = wr_ptr_r;
    cm_ptr_nxt_s  = cm_ptr_r;
    mwr_ptr_nxt_s = mwr_ptr_r;

    if (rd_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + DPTR_ONE_C;
      if (data_rd_s[DATA_WIDTH]) begin
        mrd_ptr_nxt_s = mrd_ptr_r + MPTR_ONE_C;
      end else begin
        mrd_ptr_nxt_s = mrd_ptr_r;
      end
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    if (REVERT) begin
      wr_ptr_nxt_s = cm_ptr_r;
    end else if (data_we_s) begin
      wr_ptr_nxt_s = wr_ptr_r + DPTR_ONE_C;
      if (COMMIT) begin
        cm_ptr_nxt_s  = wr_ptr_r + DPTR_ONE_C;
        mwr_ptr_nxt_s = mwr_ptr_r + MPTR_ONE_C;
      end else begin
        cm_ptr_nxt_s = cm_ptr_r;
      end
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    occ_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
    mcnt_nxt_s = mwr_ptr_nxt_s - mrd_ptr_nxt_s;

    status_nxt_s.full       = (occ_nxt_s == DATA_ENTRIES_C) | (mcnt_nxt_s == META_ENTRIES_C);
    status_nxt_s.empty      = (mcnt_nxt_s == META_NONE_C);
    status_nxt_s.rderr      = RDEN & status_r.empty;
    status_nxt_s.wrerr      = WREN & status_r.full;
    status_nxt_s.below_low  = (occ_nxt_s < LOW_TH_C);
    status_nxt_s.above_high = (occ_nxt_s > HIGH_TH_C);
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_r  <= {(DATA_DEPTH+1){1'b0}};
      wr_ptr_r  <= {(DATA_DEPTH+1){1'b0}};
      cm_ptr_r  <= {(DATA_DEPTH+1){1'b0}};
      mrd_ptr_r <= {(METADATA_DEPTH+1){1'b0}};
      mwr_ptr_r <= {(METADATA_DEPTH+1){1'b0}};
      status_r  <= STATUS_RESET_C;
    end else begin
      rd_ptr_r  <= rd_ptr_nxt_s;
      wr_ptr_r  <= wr_ptr_nxt_s;
      cm_ptr_r  <= cm_ptr_nxt_s;
      mrd_ptr_r <= mrd_ptr_nxt_s;
      mwr_ptr_r <= mwr_ptr_nxt_s;
      status_r  <= status_nxt_s;
    end
  end

  assign FULL       = status_r.full;
  assign EMPTY      = status_r.empty;
  assign RDERR      = status_r.rderr;
  assign WRERR      = status_r.wrerr;
  assign BELOW_LOW  = status_r.below_low;
  assign ABOVE_HIGH = status_r.above_high;

  assign DO  = status_r.empty ? {DATA_WIDTH{1'b0}} : data_rd_s[DATA_WIDTH-1:0];
  assign EOP = ~status_r.empty & data_rd_s[DATA_WIDTH];
  assign MO  = status_r.empty ? {METADATA_WIDTH{1'b0}} : meta_rd_s;

endmodule

// File: tb/tb_upb_packet_fifo.sv
// Directed self-checking bench for upb_packet_fifo; status vector order is
// {FULL, EMPTY, RDERR, WRERR, BELOW_LOW, ABOVE_HIGH}.
module tb_upb_packet_fifo;

  logic        CLK;
  logic        RST;
  logic [31:0] DI;
  logic [7:0]  MI;
  logic        WREN, COMMIT, REVERT, RDEN;
  logic [31:0] DO;
  logic [7:0]  MO;
  logic        EOP, FULL, EMPTY, RDERR, WRERR, BELOW_LOW, ABOVE_HIGH;
  logic [5:0]  st;

  int errors = 0;
  int checks = 0;

  upb_packet_fifo dut (
    .CLK(CLK), .RST(RST), .DI(DI), .MI(MI), .WREN(WREN), .COMMIT(COMMIT),
    .REVERT(REVERT), .RDEN(RDEN), .DO(DO), .MO(MO), .EOP(EOP), .FULL(FULL),
    .EMPTY(EMPTY), .RDERR(RDERR), .WRERR(WRERR), .BELOW_LOW(BELOW_LOW),
    .ABOVE_HIGH(ABOVE_HIGH)
  );

  assign st = {FULL, EMPTY, RDERR, WRERR, BELOW_LOW, ABOVE_HIGH};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic cyc(input logic wren, input logic commit, input logic revert,
                     input logic rden, input logic [31:0] di, input logic [7:0] mi);
    WREN = wren; COMMIT = commit; REVERT = revert; RDEN = rden; DI = di; MI = mi;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
  endtask

  initial begin
    logic [31:0] exp_do [4];
    logic        exp_eop [4];
    int          occ;
    exp_do[0] = 32'hdeadbeef; exp_do[1] = 32'haffedeaf;
    exp_do[2] = 32'hdeadbeef; exp_do[3] = 32'haffedeaf;
    exp_eop[0] = 1'b0; exp_eop[1] = 1'b0; exp_eop[2] = 1'b0; exp_eop[3] = 1'b1;

    RST = 1'b1;
    WREN = 1'b0; COMMIT = 1'b0; REVERT = 1'b0; RDEN = 1'b0; DI = 32'h0; MI = 8'h0;
    idle();
    idle();
    chk("reset_status", st, 6'b010010);
    chk("reset_do", DO, 32'h0);
    chk("reset_mo", MO, 8'h0);
    chk("reset_eop", EOP, 1'b0);
    RST = 1'b0;
    idle();

    // Uncommitted word stays invisible
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hdeadbeef, 8'h0);
    chk("uncommitted_status", st, 6'b010010);
    chk("uncommitted_do", DO, 32'h0);
    idle();
    chk("pause_status", st, 6'b010010);
    chk("pause_do", DO, 32'h0);

    // Complete and commit a 4-word packet
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'haffedeaf, 8'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hdeadbeef, 8'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'haffedeaf, 8'h55);
    chk("commit_status", st, 6'b000000);
    chk("commit_mo", MO, 8'h55);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pkt_do_%0d", i), DO, exp_do[i]);
      chk($sformatf("pkt_eop_%0d", i), EOP, exp_eop[i]);
      chk($sformatf("pkt_mo_%0d", i), MO, 8'h55);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);
    end
    chk("drained_status", st, 6'b010010);
    chk("drained_do", DO, 32'h0);
    chk("drained_mo", MO, 8'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);
    chk("rderr_pulse", st, 6'b011010);
    idle();
    chk("rderr_clear", st, 6'b010010);

    // Overfill an uncommitted packet, then revert on the 11th word
    for (int k = 1; k <= 11; k++) begin
      cyc(1'b1, 1'b0, (k == 11), 1'b0, k, 8'h0);
      occ = (k == 11) ? 0 : ((k > 8) ? 8 : k);
      chk($sformatf("fill_%0d", k), st,
          {(k >= 8 && k <= 10), 1'b1, 1'b0, (k >= 9), (occ < 3), (occ > 5)});
    end
    idle();
    chk("revert_idle", st, 6'b010010);

    // Four one-word packets fill the metadata store
    for (int p = 0; p < 4; p++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + p, 8'ha0 + p[7:0]);
      chk($sformatf("meta_fill_%0d", p), st,
          {(p == 3), 1'b0, 1'b0, 1'b0, (p + 1 < 3), 1'b0});
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h999, 8'hee);
    chk("meta_full_wrerr", st, 6'b100100);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 8'h0);
    chk("meta_full_hold", st, 6'b100000);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("meta_do_%0d", p), DO, 32'h100 + p);
      chk($sformatf("meta_mo_%0d", p), MO, 8'ha0 + p[7:0]);
      chk($sformatf("meta_eop_%0d", p), EOP, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);
    end
    chk("meta_drained", st, 6'b010010);

    // Commit and revert together discard the packet
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h77, 8'h33);
    chk("cr_status", st, 6'b010010);
    chk("cr_do", DO, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h88, 8'h44);
    chk("after_cr_do", DO, 32'h88);
    chk("after_cr_mo", MO, 8'h44);
    chk("after_cr_eop", EOP, 1'b1);

    // Reset with one committed packet and a partial one
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h99, 8'h0);
    RST = 1'b1;
    idle();
    chk("rst_mid_status", st, 6'b010010);
    chk("rst_mid_do", DO, 32'h0);
    chk("rst_mid_mo", MO, 8'h0);
    chk("rst_mid_eop", EOP, 1'b0);
    RST = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h5a, 8'h5b);
    chk("post_rst_do", DO, 32'h5a);
    chk("post_rst_mo", MO, 8'h5b);
    chk("post_rst_status", st, 6'b000010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
